// File: rtl/l2_cache_nway.sv
// N-way set-associative, write-back / write-allocate L2 cache with tree-PLRU replacement,
// invalid-first victim selection and saturating hit/miss counters.
module l2_cache_nway #(
   parameter int unsigned S_INDEX  = 3,
   parameter int unsigned WAYS     = 4,
   parameter int unsigned S_OFFSET = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [31:0]  mem_address,
   input  logic [255:0] mem_wdata256,
   input  logic [31:0]  mem_byte_enable256,
   output logic [255:0] mem_rdata256,
   output logic         mem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
);
   localparam int unsigned NUM_SETS = 2 ** S_INDEX;
   localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX;
   localparam int unsigned LW       = $clog2(WAYS);

   typedef enum logic [1:0] {StIdle, StCheck, StWb, StFill} state_e;

   state_e             state_q;
   logic [255:0]       data_q  [NUM_SETS][WAYS];
   logic [S_TAG-1:0]   tag_q   [NUM_SETS][WAYS];
   logic [WAYS-1:0]    valid_q [NUM_SETS];
   logic [WAYS-1:0]    dirty_q [NUM_SETS];
   logic [WAYS-1:1]    plru_q  [NUM_SETS];
   logic               recheck_q;
   logic [LW-1:0]      victim_q;
   logic [31:0]        hit_cnt_q;
   logic [31:0]        miss_cnt_q;

   logic [S_INDEX-1:0] idx;
   logic [S_TAG-1:0]   tag;
   logic               hit;
   logic [LW-1:0]      hit_way;
   logic [LW-1:0]      victim;
   logic [31:0]        fill_addr;
   logic               unused_offset;

   assign idx           = mem_address[S_OFFSET +: S_INDEX];
   assign tag           = mem_address[31 -: S_TAG];
   assign fill_addr     = {mem_address[31:S_OFFSET], S_OFFSET'(0)};
   assign unused_offset = ^mem_address[S_OFFSET-1:0];

   // Every node on the accessed way's path is flipped to point away from that way.
   function automatic logic [WAYS-1:1] plru_touch(input logic [WAYS-1:1] cur,
                                                  input logic [LW-1:0]   way);
      logic [WAYS-1:1] nxt;
      logic [LW-1:0]   node;
      logic            b;
      nxt  = cur;
      node = LW'(1);
      for (int l = LW - 1; l >= 0; l--) begin
         b         = way[l];
         nxt[node] = ~b;
         node      = (node << 1) | LW'(b);
      end
      return nxt;
   endfunction

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = LW'(w);
         end
      end
   end

   always_comb begin
      logic          found;
      logic [LW-1:0] node;
      logic          b;
      victim = '0;
      found  = 1'b0;
      node   = LW'(1);
      b      = 1'b0;
      // Descending scan so the lowest-index invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) begin
            victim = LW'(w);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int l = 0; l < LW; l++) begin
            b      = plru_q[idx][node];
            victim = (victim << 1) | LW'(b);
            node   = (node << 1) | LW'(b);
         end
      end
   end

   assign mem_resp     = (state_q == StCheck) && hit;
   assign mem_rdata256 = mem_resp ? data_q[idx][hit_way] : '0;
   assign hit_count    = hit_cnt_q;
   assign miss_count   = miss_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         recheck_q    <= 1'b0;
         victim_q     <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         case (state_q)
            StIdle: begin
               if (mem_read | mem_write) begin
                  state_q   <= StCheck;
                  recheck_q <= 1'b0;
               end
            end
            StCheck: begin
               if (hit) begin
                  state_q     <= StIdle;
                  plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                  if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
                  if (!recheck_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
               end else begin
                  victim_q <= victim;
                  if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
                  if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                     state_q      <= StWb;
                     pmem_write   <= 1'b1;
                     pmem_address <= {tag_q[idx][victim], idx, S_OFFSET'(0)};
                     pmem_wdata   <= data_q[idx][victim];
                  end else begin
                     state_q      <= StFill;
                     pmem_read    <= 1'b1;
                     pmem_address <= fill_addr;
                  end
               end
            end
            StWb: begin
               if (pmem_resp) begin
                  dirty_q[idx][victim_q] <= 1'b0;
                  pmem_write             <= 1'b0;
                  pmem_read              <= 1'b1;
                  pmem_address           <= fill_addr;
                  state_q                <= StFill;
               end
            end
            StFill: begin
               if (pmem_resp) begin
                  pmem_read              <= 1'b0;
                  valid_q[idx][victim_q] <= 1'b1;
                  dirty_q[idx][victim_q] <= 1'b0;
                  plru_q[idx]            <= plru_touch(plru_q[idx], victim_q);
                  recheck_q              <= 1'b1;
                  state_q                <= StCheck;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Line storage is not reset; validity alone decides what is meaningful.
   always_ff @(posedge clk) begin
      if (state_q == StFill && pmem_resp) begin
         data_q[idx][victim_q] <= pmem_rdata;
         tag_q[idx][victim_q]  <= tag;
      end else if (state_q == StCheck && hit && mem_write) begin
         for (int b = 0; b < 32; b++) begin
            if (mem_byte_enable256[b]) data_q[idx][hit_way][8*b +: 8] <= mem_wdata256[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Randomised self-checking bench for l2_cache_nway against a line-level behavioural cache model
// and a backing-memory model that answers pmem requests with random latency.
module tb_l2_cache_nway;
   localparam int unsigned S_INDEX = 3;
   localparam int unsigned WAYS    = 4;
   localparam int          NSETS   = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read, mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata256;
   logic [31:0]  mem_byte_enable256;
   logic [255:0] mem_rdata256;
   logic         mem_resp;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [31:0]  hit_count, miss_count;

   always #5 clk = ~clk;

   l2_cache_nway #(.S_INDEX(S_INDEX), .WAYS(WAYS), .S_OFFSET(5)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
      .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   bit           m_valid [NSETS][WAYS];
   bit           m_dirty [NSETS][WAYS];
   int unsigned  m_tag   [NSETS][WAYS];
   logic [255:0] m_data  [NSETS][WAYS];
   bit           m_tree  [NSETS][WAYS];
   logic [31:0]  m_hits, m_miss;
   logic [255:0] mem_store [int unsigned];

   bit           tr_write [2];
   logic [31:0]  tr_addr  [2];
   int           last_ntr;
   logic [255:0] last_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_line(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mem_line(input int unsigned ln);
      logic [255:0] v;
      if (mem_store.exists(ln)) return mem_store[ln];
      for (int k = 0; k < 8; k++) v[32*k +: 32] = (ln * 32'h0100_0193 + k * 32'h1111_1111) ^ 32'hA5A5_5A5A;
      return v;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] x);
      return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NSETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_tree[s][w]  = 1'b0;
         end
      m_hits = '0;
      m_miss = '0;
   endtask

   // Heap tree: walk down from the root, leaf number minus WAYS is the way.
   function automatic int model_victim(input int s);
      int node;
      for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
      node = 1;
      while (node < WAYS) node = 2 * node + int'(m_tree[s][node]);
      return node - WAYS;
   endfunction

   // Walk up from the leaf; a left child makes its parent point right and vice versa.
   task automatic model_touch(input int s, input int way);
      int node;
      node = way + WAYS;
      while (node > 1) begin
         m_tree[s][node / 2] = (node % 2 == 0);
         node = node / 2;
      end
   endtask

   task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [31:0] be, output bit was_hit);
      int s, way, cyc, wait_n, ntr, wb_cyc, fill_cyc;
      int unsigned tg;
      bit exp_hit, exp_wb, got;
      logic [31:0] wb_addr, fill_addr;
      logic [255:0] wb_data, exp_rd;
      s       = int'(addr[7:5]);
      tg      = {8'h00, addr[31:8]};
      exp_hit = 1'b0;
      way     = 0;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == tg) begin
            exp_hit = 1'b1;
            way     = w;
         end
      exp_wb    = 1'b0;
      wb_addr   = '0;
      wb_data   = '0;
      fill_addr = {addr[31:5], 5'b0};
      if (!exp_hit) begin
         way = model_victim(s);
         if (m_valid[s][way] && m_dirty[s][way]) begin
            exp_wb  = 1'b1;
            wb_addr = {m_tag[s][way][23:0], s[2:0], 5'b0};
            wb_data = m_data[s][way];
            mem_store[wb_addr >> 5] = wb_data;
         end
         m_data[s][way]  = mem_line(fill_addr >> 5);
         m_tag[s][way]   = tg;
         m_valid[s][way] = 1'b1;
         m_dirty[s][way] = 1'b0;
         m_miss = sat_inc(m_miss);
      end else begin
         m_hits = sat_inc(m_hits);
      end
      model_touch(s, way);
      exp_rd = m_data[s][way];
      if (wr) begin
         for (int b = 0; b < 32; b++) if (be[b]) m_data[s][way][8*b +: 8] = wd[8*b +: 8];
         m_dirty[s][way] = 1'b1;
      end

      @(negedge clk);
      mem_address        = addr;
      mem_read           = rd;
      mem_write          = wr;
      mem_wdata256       = wd;
      mem_byte_enable256 = be;
      cyc = 0; got = 1'b0; wait_n = -1; ntr = 0; wb_cyc = 0; fill_cyc = 0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         pmem_resp = 1'b0;
         check("pmem_exclusive", 32'(pmem_read & pmem_write), 32'd0);
         if (mem_resp) begin
            got        = 1'b1;
            last_rdata = mem_rdata256;
            if (!wr) check_line("rdata", mem_rdata256, exp_rd);
         end else if (pmem_read || pmem_write) begin
            if (pmem_write) wb_cyc++;
            else fill_cyc++;
            if (wait_n < 0) begin
               if (ntr == 0 && exp_wb) begin
                  check("wb_kind", 32'(pmem_write), 32'd1);
                  check("wb_addr", pmem_address, wb_addr);
                  check_line("wb_data", pmem_wdata, wb_data);
               end else begin
                  check("fill_kind", 32'(pmem_read), 32'd1);
                  check("fill_addr", pmem_address, fill_addr);
               end
               if (ntr < 2) begin
                  tr_write[ntr] = pmem_write;
                  tr_addr[ntr]  = pmem_address;
               end
               ntr++;
               wait_n = $urandom_range(0, 3);
            end
            if (wait_n == 0) begin
               pmem_resp  = 1'b1;
               pmem_rdata = mem_line(pmem_address >> 5);
               wait_n     = -1;
            end else begin
               wait_n--;
            end
         end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: no mem_resp for address %h within 200 cycles", addr);
      end
      check("latency", 32'(cyc), exp_hit ? 32'd1 : 32'(2 + wb_cyc + fill_cyc));
      check("transactions", 32'(ntr), exp_hit ? 32'd0 : (exp_wb ? 32'd2 : 32'd1));
      @(posedge clk);
      @(negedge clk);
      pmem_resp = 1'b0;
      check("resp_pulse", 32'(mem_resp), 32'd0);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_miss);
      last_ntr = ntr;
      was_hit  = got && (ntr == 0);
   endtask

   task automatic rd_req(input logic [31:0] a, output bit h);
      do_req(1'b0, 1'b1, a, '0, '0, h);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit h;
      logic [255:0] line0, wd;
      logic [31:0] a;
      bit wr, rd;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
      mem_wdata256 = '0; mem_byte_enable256 = '0; pmem_rdata = '0; pmem_resp = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mem_resp", 32'(mem_resp), 32'd0);
      check("rst_pmem_read", 32'(pmem_read), 32'd0);
      check("rst_pmem_write", 32'(pmem_write), 32'd0);
      check("rst_pmem_address", pmem_address, 32'd0);
      check("rst_hit_count", hit_count, 32'd0);
      check("rst_miss_count", miss_count, 32'd0);
      rst = 1'b0;
      model_reset();

      // Abandon a fill with an asynchronous reset.
      @(negedge clk);
      mem_address = 32'h100;
      mem_read    = 1'b1;
      for (int i = 0; i < 10 && !pmem_read; i++) @(negedge clk);
      check("fill_started", 32'(pmem_read), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_drops_read", 32'(pmem_read), 32'd0);
      check("rst_clears_miss", miss_count, 32'd0);
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Cold miss then repeat hit.
      rd_req(32'h100, h);
      check("cold_is_miss", 32'(h), 32'd0);
      check("cold_one_fill", 32'(last_ntr), 32'd1);
      check("cold_fill_kind", 32'(tr_write[0]), 32'd0);
      check("cold_fill_addr", tr_addr[0], 32'h100);
      check("cold_miss_count", miss_count, 32'd1);
      rd_req(32'h100, h);
      check("repeat_is_hit", 32'(h), 32'd1);
      check("repeat_hit_count", hit_count, 32'd1);

      // Partial write hit, then read back.
      line0 = mem_line(32'h8);
      do_req(1'b1, 1'b0, 32'h100, {32{8'hAA}}, 32'h0000_000F, h);
      check("write_is_hit", 32'(h), 32'd1);
      rd_req(32'h104, h);
      check_line("write_merge", last_rdata, {line0[255:32], 32'hAAAA_AAAA});

      // Spurious pmem_resp while idle must be ignored.
      @(negedge clk); pmem_resp = 1'b1;
      @(negedge clk); pmem_resp = 1'b0;
      check("spurious_read", 32'(pmem_read), 32'd0);
      check("spurious_write", 32'(pmem_write), 32'd0);

      // PLRU: fill ways 0..3 of set 1, hit way 0, next miss replaces way 2.
      for (int k = 0; k < 4; k++) rd_req(32'h020 + 32'(k) * 32'h100, h);
      rd_req(32'h020, h);
      rd_req(32'h420, h);
      check("plru_new_miss", 32'(h), 32'd0);
      rd_req(32'h020, h); check("plru_way0_kept", 32'(h), 32'd1);
      rd_req(32'h120, h); check("plru_way1_kept", 32'(h), 32'd1);
      rd_req(32'h320, h); check("plru_way3_kept", 32'(h), 32'd1);
      rd_req(32'h220, h); check("plru_way2_evicted", 32'(h), 32'd0);

      // Dirty eviction in set 0: the dirty 0x100 line is the PLRU victim.
      rd_req(32'h200, h);
      rd_req(32'h300, h);
      rd_req(32'h400, h);
      rd_req(32'h500, h);
      check("evict_two_trans", 32'(last_ntr), 32'd2);
      check("evict_wb_first", 32'(tr_write[0]), 32'd1);
      check("evict_wb_addr", tr_addr[0], 32'h100);
      check("evict_fill_second", 32'(tr_write[1]), 32'd0);
      check("evict_fill_addr", tr_addr[1], 32'h500);

      // Random traffic over a small address pool to force conflicts.
      for (int i = 0; i < 400; i++) begin
         a  = (32'($urandom_range(0, 11)) << 8) | (32'($urandom_range(0, 7)) << 5)
              | 32'($urandom_range(0, 31));
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
         do_req(wr, rd, a, wd, $urandom, h);
      end

      // Saturation: preload both counters one below the ceiling.
      @(negedge clk);
      dut.hit_cnt_q  = 32'hFFFF_FFFE;
      dut.miss_cnt_q = 32'hFFFF_FFFE;
      m_hits = 32'hFFFF_FFFE;
      m_miss = 32'hFFFF_FFFE;
      rd_req(32'hF000, h); check("sat_miss1", 32'(h), 32'd0);
      rd_req(32'hF000, h); check("sat_hit1", 32'(h), 32'd1);
      rd_req(32'hF000, h); check("sat_hit2", 32'(h), 32'd1);
      rd_req(32'hF000, h); check("sat_hit3", 32'(h), 32'd1);
      rd_req(32'hF100, h); check("sat_miss2", 32'(h), 32'd0);
      rd_req(32'hF200, h); check("sat_miss3", 32'(h), 32'd0);
      check("sat_hit_count", hit_count, 32'hFFFF_FFFF);
      check("sat_miss_count", miss_count, 32'hFFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
